// File: rtl/xc_fifo_pkg.sv
// xc_sync_fifo_flex shared package: read-mode constants and
// occupancy helper used by the FIFO top.
package xc_fifo_pkg;

  localparam int XC_FIFO_STD  = 0;
  localparam int XC_FIFO_FWFT = 1;

  function automatic logic [31:0] xc_fifo_level(
    input logic        wr_ph,
    input logic [31:0] wr_idx,
    input logic        rd_ph,
    input logic [31:0] rd_idx,
    input logic [31:0] depth
  );
    if (wr_ph == rd_ph) return wr_idx - rd_idx;
    else return depth + wr_idx - rd_idx;
  endfunction

endpackage

// File: rtl/xc_fifo_ptr.sv
// xc_fifo_ptr: index 0..DEPTH-1 with phase bit that toggles
// on every wrap, so equal indices can be told apart.
module xc_fifo_ptr
  import xc_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] idx_o,
  output logic          ph_o
);

  logic [AW-1:0] idx_q, idx_d;
  logic          ph_q, ph_d;

  // next index: wrap to zero at DEPTH-1 and flip phase
  always_comb begin
    idx_d = idx_q;
    ph_d  = ph_q;
    if (inc_i) begin
      if (idx_q == AW'(DEPTH - 1)) begin
        idx_d = '0;
        ph_d  = ~ph_q;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
  end

  // pointer state, cleared by reset or clear
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      idx_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      ph_q  <= ph_d;
    end
  end

  assign idx_o = idx_q;
  assign ph_o  = ph_q;

endmodule

// File: rtl/xc_sync_fifo_flex.sv
// xc_sync_fifo_flex: single-clock FIFO, any depth, STD/FWFT.
// Sticky ovf/udf flags built only with XC_SYNC_FIFO_ERR_EN.
module xc_sync_fifo_flex
  import xc_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  parameter  int FWFT  = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             ne_o,
  output logic [AW:0]      level_o,
  input  logic [AW:0]      af_count_i,
  input  logic [AW:0]      ae_count_i,
  output logic             af_o,
  output logic             ae_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam bit IS_FWFT = (FWFT == XC_FIFO_FWFT);

  logic [AW-1:0]    wr_idx, rd_idx;
  logic             wr_ph, rd_ph;
  logic [AW:0]      ram_cnt, level;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             flush, pop, push, load;
  logic             wr_inc, rd_inc;

  assign flush = rst_i | clr_i;

  assign ram_cnt = (AW+1)'(xc_fifo_level(
    wr_ph, 32'(wr_idx), rd_ph, 32'(rd_idx), 32'(DEPTH)));

  // FWFT output register counts toward occupancy
  assign level = IS_FWFT
               ? ram_cnt + (AW+1)'(valid_q)
               : ram_cnt;

  assign full_o  = (level == (AW+1)'(DEPTH));
  assign ne_o    = (level != '0);
  assign level_o = level;
  assign af_o    = (level >= af_count_i);
  assign ae_o    = (level <= ae_count_i);

  assign pop  = IS_FWFT ? (rd_i && valid_q)
                        : (rd_i && ne_o);
  assign push = wr_i && (!full_o || pop);
  assign load = (ram_cnt != '0) && (!valid_q || pop);

  assign wr_inc = !flush && push;
  assign rd_inc = !flush && (IS_FWFT ? load : pop);

  xc_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (wr_inc),
    .idx_o (wr_idx),
    .ph_o  (wr_ph)
  );

  xc_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (rd_inc),
    .idx_o (rd_idx),
    .ph_o  (rd_ph)
  );

  // storage; read-before-write keeps write-through-when-full safe
  always_ff @(posedge clk_i) begin
    if (wr_inc) mem[wr_idx] <= data_i;
  end

  // output register: prefetch in FWFT, read strobe in STD
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (IS_FWFT) begin
      if (load) begin
        data_d  = mem[rd_idx];
        valid_d = 1'b1;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = pop;
      if (pop) data_d = mem[rd_idx];
    end
  end

  // output register state
  always_ff @(posedge clk_i) begin
    if (flush) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef XC_SYNC_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // sticky error flags, only cleared by reset or clear
  always_ff @(posedge clk_i) begin
    if (flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_i && !push) ovf_q <= 1'b1;
      if (rd_i && !pop)  udf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_xc_sync_fifo_flex.sv
// Directed bench: one STD and one FWFT instance, DEPTH=6.
// Flag expectations follow XC_SYNC_FIFO_ERR_EN.
module tb_xc_sync_fifo_flex;

`ifdef XC_SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  af_c = 4'd5;
  logic [3:0]  ae_c = 4'd1;

  logic        s_rst, s_clr, s_wr, s_rd;
  logic [15:0] s_din, s_dout;
  logic        s_valid, s_full, s_ne, s_af, s_ae;
  logic        s_ovf, s_udf;
  logic [3:0]  s_level;

  logic        f_rst, f_clr, f_wr, f_rd;
  logic [15:0] f_din, f_dout;
  logic        f_valid, f_full, f_ne, f_af, f_ae;
  logic        f_ovf, f_udf;
  logic [3:0]  f_level;

  logic [15:0] exp_d [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xc_sync_fifo_flex #(.WIDTH(16), .DEPTH(6), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(s_rst), .clr_i(s_clr),
    .wr_i(s_wr), .data_i(s_din), .rd_i(s_rd),
    .data_o(s_dout), .valid_o(s_valid),
    .full_o(s_full), .ne_o(s_ne), .level_o(s_level),
    .af_count_i(af_c), .ae_count_i(ae_c),
    .af_o(s_af), .ae_o(s_ae),
    .ovf_o(s_ovf), .udf_o(s_udf)
  );

  xc_sync_fifo_flex #(.WIDTH(16), .DEPTH(6), .FWFT(1)) u_fw (
    .clk_i(clk), .rst_i(f_rst), .clr_i(f_clr),
    .wr_i(f_wr), .data_i(f_din), .rd_i(f_rd),
    .data_o(f_dout), .valid_o(f_valid),
    .full_o(f_full), .ne_o(f_ne), .level_o(f_level),
    .af_count_i(af_c), .ae_count_i(ae_c),
    .af_o(f_af), .ae_o(f_ae),
    .ovf_o(f_ovf), .udf_o(f_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_d = '{16'h55, 16'h11, 16'h12, 16'h13, 16'h14,
              16'h15, 16'h20, 16'h21, 16'h22, 16'h23};
    s_rst = 1; s_clr = 0; s_wr = 0; s_rd = 0; s_din = 0;
    f_rst = 1; f_clr = 0; f_wr = 0; f_rd = 0; f_din = 0;
    tick();
    s_rst = 0; f_rst = 0;

    // reset state
    chk("s_rst_level", 32'(s_level), 0);
    chk("s_rst_ne", 32'(s_ne), 0);
    chk("s_rst_full", 32'(s_full), 0);
    chk("s_rst_valid", 32'(s_valid), 0);
    chk("s_rst_data", 32'(s_dout), 0);
    chk("s_rst_ae", 32'(s_ae), 1);
    chk("s_rst_af", 32'(s_af), 0);
    chk("s_rst_ovf", 32'(s_ovf), 0);
    chk("s_rst_udf", 32'(s_udf), 0);
    chk("f_rst_level", 32'(f_level), 0);
    chk("f_rst_valid", 32'(f_valid), 0);

    // STD fill 1..6 with thresholds and wrap
    s_wr = 1;
    for (int i = 1; i <= 6; i++) begin
      s_din = 16'(i);
      tick();
      chk("s_fill_level", 32'(s_level), 32'(i));
      chk("s_fill_ae", 32'(s_ae), 32'(i <= 1));
      chk("s_fill_af", 32'(s_af), 32'(i >= 5));
      chk("s_fill_full", 32'(s_full), 32'(i == 6));
      chk("s_fill_widx", 32'(u_std.u_wr_ptr.idx_o),
          32'(i % 6));
    end
    s_din = 16'h7;
    tick();
    s_wr = 0;
    chk("s_ovf_level", 32'(s_level), 6);
    chk("s_ovf_flag", 32'(s_ovf), 32'(ERR));

    // STD read back, one cycle latency
    s_rd = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s_rd_data", 32'(s_dout), 32'(i));
      chk("s_rd_valid", 32'(s_valid), 1);
      chk("s_rd_level", 32'(s_level), 32'(6 - i));
    end
    tick();
    s_rd = 0;
    chk("s_empty_rd_valid", 32'(s_valid), 0);
    chk("s_empty_rd_data", 32'(s_dout), 6);
    chk("s_empty_rd_udf", 32'(s_udf), 32'(ERR));

    // clear, then simultaneous wr/rd on empty
    s_clr = 1;
    tick();
    s_clr = 0;
    chk("s_clr_udf", 32'(s_udf), 0);
    chk("s_clr_ovf", 32'(s_ovf), 0);
    s_wr = 1; s_rd = 1; s_din = 16'h55;
    tick();
    s_rd = 0;
    chk("s_wrrd_level", 32'(s_level), 1);
    chk("s_wrrd_valid", 32'(s_valid), 0);
    chk("s_wrrd_udf", 32'(s_udf), 32'(ERR));
    chk("s_wrrd_ovf", 32'(s_ovf), 0);

    // refill to full
    for (int i = 1; i <= 5; i++) begin
      s_din = 16'(8'h10 + i);
      tick();
    end
    chk("s_refill_level", 32'(s_level), 6);
    chk("s_refill_full", 32'(s_full), 1);

    // full with wr/rd each cycle
    s_rd = 1;
    for (int k = 0; k < 10; k++) begin
      s_din = 16'(8'h20 + k);
      tick();
      chk("s_thru_data", 32'(s_dout), 32'(exp_d[k]));
      chk("s_thru_level", 32'(s_level), 6);
    end
    s_wr = 0;
    chk("s_thru_ovf", 32'(s_ovf), 0);
    tick();
    chk("s_mid_data0", 32'(s_dout), 32'h24);
    tick();
    chk("s_mid_data1", 32'(s_dout), 32'h25);
    chk("s_mid_level", 32'(s_level), 4);

    // clear mid-stream overrides wr/rd
    s_clr = 1; s_wr = 1;
    tick();
    s_clr = 0; s_wr = 0; s_rd = 0;
    chk("s_clr2_level", 32'(s_level), 0);
    chk("s_clr2_valid", 32'(s_valid), 0);
    chk("s_clr2_data", 32'(s_dout), 0);
    chk("s_clr2_ovf", 32'(s_ovf), 0);
    chk("s_clr2_udf", 32'(s_udf), 0);
    chk("s_clr2_ne", 32'(s_ne), 0);

    // FWFT single word latency
    f_wr = 1; f_din = 16'hA5A5;
    tick();
    f_wr = 0;
    chk("f_one_valid0", 32'(f_valid), 0);
    chk("f_one_level0", 32'(f_level), 1);
    tick();
    chk("f_one_valid1", 32'(f_valid), 1);
    chk("f_one_data1", 32'(f_dout), 32'hA5A5);
    chk("f_one_level1", 32'(f_level), 1);
    f_rd = 1;
    tick();
    f_rd = 0;
    chk("f_pop_valid", 32'(f_valid), 0);
    chk("f_pop_level", 32'(f_level), 0);
    chk("f_pop_udf", 32'(f_udf), 0);

    // FWFT fill and back-to-back drain
    f_wr = 1;
    for (int i = 1; i <= 6; i++) begin
      f_din = 16'(i);
      tick();
      chk("f_fill_level", 32'(f_level), 32'(i));
    end
    f_wr = 0;
    chk("f_fill_full", 32'(f_full), 1);
    chk("f_head_data", 32'(f_dout), 1);
    f_rd = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("f_drain_data", 32'(f_dout), 32'(k + 1));
      chk("f_drain_valid", 32'(f_valid), 1);
      chk("f_drain_level", 32'(f_level), 32'(6 - k));
    end
    tick();
    f_rd = 0;
    chk("f_drain_end_valid", 32'(f_valid), 0);
    chk("f_drain_end_level", 32'(f_level), 0);
    chk("f_drain_end_ne", 32'(f_ne), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
